// File: rtl/rng_sample_arbiter.sv
// rng_sample_arbiter: round-robin sharing of one LFSR sample source among NREQ consumers.
// Optional RNG_WHITEN_EN xors each captured fraction with a Weyl sequence.
module rng_sample_arbiter #(
    parameter int NREQ = 4,
    parameter int MIN_GAP = 1,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     rnd_in,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] rsp_ready,
    output logic [NREQ-1:0] rsp_valid,
    output logic [31:0]     rsp_data,
    output logic [IDW-1:0]  rsp_id,
    output logic            busy,
    output logic [15:0]     sample_cnt
);
    typedef enum logic [1:0] {IDLE, RESP, GAP} state_t;
    state_t         state;
    logic [IDW-1:0] rr_ptr, win, cand;
    logic [3:0]     gap_cnt;
    logic [15:0]    frac;
    logic           unused_hi;
    assign unused_hi = ^rnd_in[31:16];
`ifdef RNG_WHITEN_EN
    logic [15:0] weyl;
    assign frac = rnd_in[15:0] ^ weyl;
`else
    assign frac = rnd_in[15:0];
`endif
    // Descending scan so the smallest offset from rr_ptr wins.
    always_comb begin
        win = rr_ptr;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (req[cand]) win = cand;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_id     <= '0;
            busy       <= 1'b0;
            sample_cnt <= '0;
            rr_ptr     <= '0;
            gap_cnt    <= '0;
`ifdef RNG_WHITEN_EN
            weyl       <= 16'h9E37;
`endif
        end else begin
            case (state)
                IDLE: if (|req) begin
                    rsp_data  <= {16'h0000, frac};
                    rsp_id    <= win;
                    rsp_valid <= NREQ'(1) << win;
                    busy      <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (rsp_ready[rsp_id]) begin
                    rsp_valid <= '0;
                    rr_ptr    <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
                    if (sample_cnt != 16'hFFFF) sample_cnt <= sample_cnt + 16'd1;
                    gap_cnt   <= 4'(MIN_GAP);
                    busy      <= (MIN_GAP != 0);
                    state     <= (MIN_GAP == 0) ? IDLE : GAP;
`ifdef RNG_WHITEN_EN
                    weyl      <= weyl + 16'h9E37;
`endif
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 4'd1;
                    if (gap_cnt == 4'd1) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rng_sample_arbiter.sv
// tb_rng_sample_arbiter: randomized self-checking bench with an event-level reference model.
module tb_rng_sample_arbiter;
    localparam int NREQ = 4;
    localparam int MIN_GAP = 1;
    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     rnd_in;
    logic [NREQ-1:0] req, rsp_ready, rsp_valid;
    logic [31:0]     rsp_data;
    logic [1:0]      rsp_id;
    logic            busy;
    logic [15:0]     sample_cnt;
    int errs = 0, checks = 0, cyc = 0;
    bit m_pend;
    int m_id, m_ptr, m_n, m_ready_at;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    rng_sample_arbiter #(.NREQ(NREQ), .MIN_GAP(MIN_GAP)) dut (
        .clk(clk), .reset(reset), .rnd_in(rnd_in), .req(req), .rsp_ready(rsp_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy),
        .sample_cnt(sample_cnt)
    );

    function automatic int pick(logic [NREQ-1:0] r, int ptr);
        for (int i = 0; i < NREQ; i++)
            if (r[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        return ptr;
    endfunction

    // Weyl term for the n-th sample since reset: (n+1) * golden-ratio constant mod 2^16.
    function automatic logic [15:0] whiten(int n);
`ifdef RNG_WHITEN_EN
        return 16'((n + 1) * 32'h9E37);
`else
        return 16'h0000;
`endif
    endfunction

    function automatic logic [NREQ-1:0] m_valid();
        return m_pend ? NREQ'(1) << m_id : '0;
    endfunction

    function automatic logic [15:0] m_cnt();
        return (m_n > 65535) ? 16'hFFFF : 16'(m_n);
    endfunction

    task automatic model_reset();
        m_pend = 0; m_id = 0; m_ptr = 0; m_n = 0; m_ready_at = 0; m_data = '0;
    endtask

    // One clock edge: advance the model on the inputs seen at this edge, then settle.
    task automatic tick();
        if (m_pend) begin
            if (rsp_ready[m_id]) begin
                m_pend = 0;
                m_ptr = (m_id + 1) % NREQ;
                m_n++;
                m_ready_at = cyc + MIN_GAP + 1;
            end
        end else if (cyc >= m_ready_at && req != 0) begin
            m_pend = 1;
            m_id = pick(req, m_ptr);
            m_data = {16'h0000, rnd_in[15:0] ^ whiten(m_n)};
        end
        @(posedge clk); #1; cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1; cyc++;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        req = '0; rsp_ready = '0; rnd_in = 32'hFFFF_FFFF;
        reset = 1'b1;
        #1;
        checks++; if (rsp_valid !== '0) begin errs++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_data !== '0) begin errs++; $display("FAIL reset_data got=%h exp=0", rsp_data); end
        checks++; if (rsp_id !== '0) begin errs++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (sample_cnt !== '0) begin errs++; $display("FAIL reset_cnt got=%0d exp=0", sample_cnt); end
        @(posedge clk); #1; cyc++;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        logic [31:0] exp;
`ifdef RNG_WHITEN_EN
        exp = 32'h0000_8C03;
`else
        exp = 32'h0000_1234;
`endif
        rnd_in = 32'hABCD_1234; req = 4'b0001; rsp_ready = '0;
        tick();
        checks++; if (rsp_valid !== 4'b0001) begin errs++; $display("FAIL single_valid got=%b exp=0001", rsp_valid); end
        checks++; if (rsp_data !== exp) begin errs++; $display("FAIL single_data got=%h exp=%h", rsp_data, exp); end
        checks++; if (rsp_id !== 2'd0) begin errs++; $display("FAIL single_id got=%0d exp=0", rsp_id); end
        rsp_ready = 4'b0001; req = '0;
        tick();
        checks++; if (rsp_valid !== '0) begin errs++; $display("FAIL single_hs_valid got=%b exp=0", rsp_valid); end
        checks++; if (sample_cnt !== 16'd1) begin errs++; $display("FAIL single_cnt got=%0d exp=1", sample_cnt); end
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL single_gap_busy got=%b exp=1", busy); end
        rsp_ready = '0;
        tick();
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
`ifdef RNG_WHITEN_EN
        rnd_in = 32'h0000_1234; req = 4'b0001;
        tick();
        checks++; if (rsp_data !== 32'h0000_2E5A) begin errs++; $display("FAIL whiten_second got=%h exp=00002e5a", rsp_data); end
        rsp_ready = 4'b0001; req = '0;
        tick(); tick();
        rsp_ready = '0;
`endif
    endtask

    task automatic test_round_robin();
        int got[$];
        int exp_order[6] = '{0, 1, 3, 0, 1, 3};
        do_reset();
        req = 4'b1011; rsp_ready = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            rnd_in = $urandom;
            tick();
            checks++; if (rsp_valid !== m_valid()) begin errs++; $display("FAIL rr_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, m_valid()); end
            if (rsp_valid != 0) got.push_back(int'(rsp_id));
        end
        checks++; if (got.size() < 6) begin errs++; $display("FAIL rr_count got=%0d exp>=6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            checks++; if (got[i] != exp_order[i]) begin errs++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, got[i], exp_order[i]); end
        end
        req = '0; rsp_ready = '0;
        tick(); tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        do_reset();
        req = 4'b0100; rsp_ready = '0; rnd_in = $urandom;
        tick();
        held = m_data;
        checks++; if (rsp_id !== 2'd2) begin errs++; $display("FAIL bp_grant_id got=%0d exp=2", rsp_id); end
        rsp_ready = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            rnd_in = $urandom;
            tick();
            checks++; if (rsp_valid !== 4'b0100) begin errs++; $display("FAIL bp_valid i=%0d got=%b exp=0100", i, rsp_valid); end
            checks++; if (rsp_data !== held) begin errs++; $display("FAIL bp_data i=%0d got=%h exp=%h", i, rsp_data, held); end
            checks++; if (rsp_id !== 2'd2) begin errs++; $display("FAIL bp_id i=%0d got=%0d exp=2", i, rsp_id); end
        end
        rsp_ready = 4'b0100;
        tick();
        checks++; if (rsp_valid !== '0) begin errs++; $display("FAIL bp_hs_valid got=%b exp=0", rsp_valid); end
        checks++; if (sample_cnt !== 16'd1) begin errs++; $display("FAIL bp_cnt got=%0d exp=1", sample_cnt); end
        req = '0; rsp_ready = '0;
        tick(); tick();
    endtask

    task automatic test_reset_mid_resp();
        do_reset();
        req = 4'b0100; rsp_ready = '0; rnd_in = $urandom;
        tick();
        checks++; if (rsp_valid !== 4'b0100) begin errs++; $display("FAIL mid_pre_valid got=%b exp=0100", rsp_valid); end
        #2 reset = 1'b1;
        #1;
        checks++; if (rsp_valid !== '0) begin errs++; $display("FAIL mid_valid got=%b exp=0", rsp_valid); end
        checks++; if (sample_cnt !== '0) begin errs++; $display("FAIL mid_cnt got=%0d exp=0", sample_cnt); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy got=%b exp=0", busy); end
        @(posedge clk); #1; cyc++;
        reset = 1'b0;
        model_reset();
        req = 4'b1111;
        tick();
        checks++; if (rsp_id !== 2'd0) begin errs++; $display("FAIL mid_ptr got=%0d exp=0", rsp_id); end
        rsp_ready = 4'b1111; req = '0;
        tick(); tick();
        rsp_ready = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            req = NREQ'($urandom_range(0, 15) & $urandom_range(0, 15));
            rsp_ready = NREQ'($urandom_range(0, 15));
            rnd_in = $urandom;
            tick();
            checks++; if (rsp_valid !== m_valid()) begin errs++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, m_valid()); end
            checks++; if (rsp_data !== m_data) begin errs++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, rsp_data, m_data); end
            checks++; if (int'(rsp_id) != m_id) begin errs++; $display("FAIL rnd_id cyc=%0d got=%0d exp=%0d", cyc, rsp_id, m_id); end
            checks++; if (busy !== (m_pend || cyc < m_ready_at)) begin errs++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, (m_pend || cyc < m_ready_at)); end
            checks++; if (sample_cnt !== m_cnt()) begin errs++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", cyc, sample_cnt, m_cnt()); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid_resp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
